// File: rtl/sm3_msg_arb.sv
// sm3_msg_arb
// Message-granular round-robin arbiter that shares a single SM3 pad/compression
// datapath between CH_NUM requesters. A channel owns the pad core from the
// cycle after it wins arbitration until the hash-complete pulse for its message
// returns. Beats from different channels therefore never interleave.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ch_en_i           per-channel arbitration enable mask
//   req_d_i           channel data, channel k at [k*DW +: DW]
//   req_vld_byte_i    channel byte-valid (MSB-first, meaningful on last beat)
//   req_vld_i         channel beat valid
//   req_lst_i         channel last beat of message
//   req_rdy_o         channel ready (only the owner, only while transferring)
//   core_d_o          data to pad core
//   core_vld_byte_o   byte-valid to pad core
//   core_vld_o        beat valid to pad core
//   core_lst_o        last beat to pad core
//   core_rdy_i        pad core message-input ready
//   res_vld_i         hash-complete pulse from the compression stage
//   res_vld_o         hash-complete pulse routed one-hot to the owner
//   gnt_id_o          index of the current (or most recent) owner
//   busy_o            high whenever a message is in flight
module sm3_msg_arb #(
  parameter int CH_NUM = 4,
  parameter int CH_W   = 2,
  parameter int DW     = 32,
  parameter int BW     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH_NUM-1:0]    ch_en_i,
  input  logic [CH_NUM*DW-1:0] req_d_i,
  input  logic [CH_NUM*BW-1:0] req_vld_byte_i,
  input  logic [CH_NUM-1:0]    req_vld_i,
  input  logic [CH_NUM-1:0]    req_lst_i,
  output logic [CH_NUM-1:0]    req_rdy_o,
  output logic [DW-1:0]        core_d_o,
  output logic [BW-1:0]        core_vld_byte_o,
  output logic                 core_vld_o,
  output logic                 core_lst_o,
  input  logic                 core_rdy_i,
  input  logic                 res_vld_i,
  output logic [CH_NUM-1:0]    res_vld_o,
  output logic [CH_W-1:0]      gnt_id_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    XFER     = 3'b010,
    WAIT_RES = 3'b100
  } state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] gnt_id_q, gnt_id_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [CH_NUM-1:0] elig;
  logic              found;
  logic [CH_W-1:0]   pick;

  // Round-robin successor; CH_NUM need not be a power of two.
  function automatic logic [CH_W-1:0] next_ptr(input logic [CH_W-1:0] g);
    if (int'(g) == CH_NUM - 1) return '0;
    else                       return g + CH_W'(1);
  endfunction

  // Search eligible channels starting at rr_ptr and wrapping around.
  always_comb begin
    int idx;
    idx   = 0;
    elig  = req_vld_i & ch_en_i;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      idx = (int'(rr_ptr_q) + i) % CH_NUM;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  // Owner pass-through. Reset forces every output low even though the state
  // register only clears at the end of the reset cycle.
  always_comb begin
    core_d_o        = '0;
    core_vld_byte_o = '0;
    core_vld_o      = 1'b0;
    core_lst_o      = 1'b0;
    req_rdy_o       = '0;
    res_vld_o       = '0;
    if (!rst) begin
      if (state_q == XFER) begin
        core_d_o            = req_d_i[int'(gnt_id_q)*DW +: DW];
        core_vld_byte_o     = req_vld_byte_i[int'(gnt_id_q)*BW +: BW];
        core_vld_o          = req_vld_i[gnt_id_q];
        core_lst_o          = req_lst_i[gnt_id_q];
        req_rdy_o[gnt_id_q] = core_rdy_i;
      end
      // A result pulse only counts once the whole message is in the core.
      if (state_q == WAIT_RES && res_vld_i) begin
        res_vld_o[gnt_id_q] = 1'b1;
      end
    end
  end

  assign gnt_id_o = rst ? '0 : gnt_id_q;
  assign busy_o   = !rst && (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_id_d = pick;
          rr_ptr_d = next_ptr(pick);
          state_d  = XFER;
        end
      end
      XFER: begin
        if (core_vld_o && core_rdy_i && core_lst_o) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_vld_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_sm3_msg_arb.sv
module tb_sm3_msg_arb;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_en_i, req_vld_i, req_lst_i, req_rdy_o, res_vld_o;
  logic [N*DW-1:0] req_d_i;
  logic [N*BW-1:0] req_vld_byte_i;
  logic [DW-1:0]   core_d_o;
  logic [BW-1:0]   core_vld_byte_o;
  logic            core_vld_o, core_lst_o, core_rdy_i, res_vld_i, busy_o;
  logic [CW-1:0]   gnt_id_o;

  sm3_msg_arb #(.CH_NUM(N), .CH_W(CW), .DW(DW), .BW(BW)) dut (
    .clk(clk), .rst(rst), .ch_en_i(ch_en_i), .req_d_i(req_d_i),
    .req_vld_byte_i(req_vld_byte_i), .req_vld_i(req_vld_i), .req_lst_i(req_lst_i),
    .req_rdy_o(req_rdy_o), .core_d_o(core_d_o), .core_vld_byte_o(core_vld_byte_o),
    .core_vld_o(core_vld_o), .core_lst_o(core_lst_o), .core_rdy_i(core_rdy_i),
    .res_vld_i(res_vld_i), .res_vld_o(res_vld_o), .gnt_id_o(gnt_id_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- requester sources ----------------
  int rem[N], msgs[N], len[N], beat[N], msgid[N];
  logic [BW-1:0] vb[N];
  bit hs[N];

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      req_vld_i[c] = (rem[c] > 0);
      req_lst_i[c] = (rem[c] == 1);
      req_d_i[c*DW +: DW] = {8'(c), 8'(msgid[c]), 16'(beat[c])};
      req_vld_byte_i[c*BW +: BW] = (rem[c] == 1) ? vb[c] : 4'hF;
    end
  endtask

  task automatic start_src(input int c, input int n, input int l, input logic [BW-1:0] v);
    len[c] = l; msgs[c] = n - 1; rem[c] = l; beat[c] = 0; msgid[c]++; vb[c] = v;
  endtask

  task automatic advance(input int c);
    beat[c]++;
    rem[c]--;
    if (rem[c] == 0 && msgs[c] > 0) begin
      msgs[c]--; rem[c] = len[c]; beat[c] = 0; msgid[c]++;
    end
  endtask

  function automatic bit src_empty();
    for (int c = 0; c < N; c++) if (rem[c] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- behavioural model ----------------
  // phase: 0 = no owner, 1 = owner sending beats, 2 = owner awaiting its hash
  int m_phase = 0, m_owner = 0, m_next = 0;
  logic [DW-1:0] e_d;
  logic [BW-1:0] e_vb;
  logic          e_vld, e_lst, e_busy;
  logic [N-1:0]  e_rdy, e_res;
  int            e_gnt;

  always @(negedge clk) begin
    e_d = '0; e_vb = '0; e_vld = 0; e_lst = 0; e_rdy = '0; e_res = '0;
    e_gnt = 0; e_busy = 0;
    if (!rst) begin
      e_gnt  = m_owner;
      e_busy = (m_phase != 0);
      if (m_phase == 1) begin
        e_d = req_d_i[m_owner*DW +: DW];
        e_vb = req_vld_byte_i[m_owner*BW +: BW];
        e_vld = req_vld_i[m_owner];
        e_lst = req_lst_i[m_owner];
        e_rdy[m_owner] = core_rdy_i;
      end
      if (m_phase == 2 && res_vld_i) e_res[m_owner] = 1'b1;
    end
    chk("core_d", 64'(core_d_o), 64'(e_d));
    chk("core_vld_byte", 64'(core_vld_byte_o), 64'(e_vb));
    chk("core_vld", 64'(core_vld_o), 64'(e_vld));
    chk("core_lst", 64'(core_lst_o), 64'(e_lst));
    chk("req_rdy", 64'(req_rdy_o), 64'(e_rdy));
    chk("res_vld", 64'(res_vld_o), 64'(e_res));
    chk("gnt_id", 64'(gnt_id_o), 64'(e_gnt));
    chk("busy", 64'(busy_o), 64'(e_busy));
    if (rst) begin
      m_phase = 0; m_owner = 0; m_next = 0;
    end else if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_next + k) % N;
        if (m_phase == 0 && req_vld_i[c] && ch_en_i[c]) begin
          m_owner = c; m_next = (c + 1) % N; m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (req_vld_i[m_owner] && core_rdy_i && req_lst_i[m_owner]) m_phase = 2;
    end else if (res_vld_i) begin
      m_phase = 0;
    end
  end

  // ---------------- observation + cycle stepping ----------------
  int cyc = 0, n_xfer, first_xfer, lst_beat, res_cyc, fall_cyc, n_stall, il_err;
  int res_cd = 0, res_dly = 0;
  logic [N-1:0] res_seen, res_or;
  logic busy_prev = 1'b0;
  int grants[$];
  int rdy_pat[$];

  task automatic clear_obs();
    n_xfer = 0; first_xfer = -1; lst_beat = -1; res_cyc = -1; fall_cyc = -1;
    n_stall = 0; il_err = 0; res_seen = '0; res_or = '0; grants.delete();
  endtask

  task automatic tick();
    @(negedge clk); #2;
    if (core_vld_o && core_rdy_i) begin
      n_xfer++;
      if (first_xfer < 0) first_xfer = cyc;
      if (int'(core_d_o[31:24]) != int'(gnt_id_o)) il_err++;
      if (core_lst_o) begin
        lst_beat = n_xfer;
        if (res_dly > 0) res_cd = res_dly;
      end
    end
    if (core_vld_o && !core_rdy_i) n_stall++;
    if (res_vld_o != '0) begin res_seen = res_vld_o; res_cyc = cyc; end
    res_or |= res_vld_o;
    if (busy_o && !busy_prev) grants.push_back(int'(gnt_id_o));
    if (!busy_o && busy_prev) fall_cyc = cyc;
    busy_prev = busy_o;
    for (int c = 0; c < N; c++) hs[c] = req_vld_i[c] & req_rdy_o[c];
    @(posedge clk); #1;
    cyc++;
    for (int c = 0; c < N; c++) if (hs[c]) advance(c);
    res_vld_i = 1'b0;
    if (res_cd > 0) begin
      res_cd--;
      if (res_cd == 0) res_vld_i = 1'b1;
    end
    if (rdy_pat.size() > 0) core_rdy_i = (rdy_pat.pop_front() != 0);
    else core_rdy_i = 1'b1;
    drive();
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int k;
    k = 0;
    while (k < maxc && !(src_empty() && !busy_o && res_cd == 0)) begin
      tick(); k++;
    end
    chk(nm, 64'(src_empty() && !busy_o && res_cd == 0), 64'(1));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int t_req, k;
  int rr_exp[6] = '{0, 2, 3, 0, 2, 3};

  initial begin
    for (int c = 0; c < N; c++) begin
      rem[c] = 0; msgs[c] = 0; len[c] = 0; beat[c] = 0; msgid[c] = 0; vb[c] = '0;
    end
    rst = 1'b1; ch_en_i = 4'hF; core_rdy_i = 1'b1; res_vld_i = 1'b0;
    req_d_i = '0; req_vld_byte_i = '0; req_vld_i = '0; req_lst_i = '0;
    drive(); clear_obs();
    tick(); tick();
    chk("reset_busy", 64'(busy_o), 64'(0));
    chk("reset_gnt", 64'(gnt_id_o), 64'(0));
    chk("reset_rdy", 64'(req_rdy_o), 64'(0));
    rst = 1'b0;

    // Round robin: 0,2,3 each with two 2-beat messages
    clear_obs(); res_dly = 2;
    start_src(0, 2, 2, 4'b1000); start_src(2, 2, 2, 4'b1100); start_src(3, 2, 2, 4'b1110);
    drive();
    wait_done("rr_done", 200);
    chk("rr_ngrant", 64'(grants.size()), 64'(6));
    for (int i = 0; i < 6; i++)
      chk("rr_order", 64'((i < grants.size()) ? grants[i] : -1), 64'(rr_exp[i]));
    chk("rr_xfers", 64'(n_xfer), 64'(12));
    chk("rr_interleave", 64'(il_err), 64'(0));

    // Single channel: ch1, 16 beats, result 5 cycles after the last beat
    clear_obs(); res_dly = 5;
    start_src(1, 1, 16, 4'b1111); drive(); t_req = cyc;
    tick();
    res_vld_i = 1'b1;  // stray result while beats are still flowing
    wait_done("single_done", 100);
    chk("single_first", 64'(first_xfer), 64'(t_req + 1));
    chk("single_beats", 64'(n_xfer), 64'(16));
    chk("single_lst", 64'(lst_beat), 64'(16));
    chk("single_res", 64'(res_seen), 64'(4'b0010));
    chk("single_busyfall", 64'(fall_cyc), 64'(res_cyc + 1));

    // Backpressure on ch3, owner mask dropped mid-message, result on last beat
    clear_obs(); res_dly = 1;
    start_src(3, 1, 4, 4'b1100); drive();
    core_rdy_i = 1'b1;
    rdy_pat = '{1, 0, 0, 1, 1, 0, 0, 1};
    tick();
    ch_en_i = 4'b0111;
    repeat (7) tick();
    res_vld_i = 1'b1;  // same cycle as the last-beat transfer
    wait_done("bp_done", 50);
    ch_en_i = 4'hF;
    chk("bp_xfers", 64'(n_xfer), 64'(4));
    chk("bp_stalls", 64'(n_stall), 64'(4));
    chk("bp_res", 64'(res_seen), 64'(4'b1000));

    // Masked requester and stray result in IDLE
    clear_obs(); res_dly = 0; ch_en_i = 4'b1101;
    start_src(1, 1, 2, 4'hF); drive();
    tick();
    res_vld_i = 1'b1;
    repeat (5) tick();
    chk("mask_ngrant", 64'(grants.size()), 64'(0));
    chk("mask_res", 64'(res_or), 64'(0));
    chk("mask_busy", 64'(busy_o), 64'(0));
    rem[1] = 0; msgs[1] = 0; drive();

    // Reset in the middle of a ch2 message
    clear_obs(); res_dly = 3;
    start_src(2, 1, 6, 4'hF); drive();
    k = 0;
    while (n_xfer < 3 && k < 50) begin tick(); k++; end
    chk("rstmid_3beats", 64'(n_xfer), 64'(3));
    rst = 1'b1; #1;
    chk("rstmid_outs", 64'({core_d_o, core_vld_byte_o, core_vld_o, core_lst_o, req_rdy_o,
                            res_vld_o, gnt_id_o, busy_o}), 64'(0));
    tick();
    rst = 1'b0;
    clear_obs();
    start_src(0, 1, 2, 4'hF); start_src(2, 1, 2, 4'hF); drive();
    wait_done("rstmid_done", 100);
    chk("rstmid_first", 64'((grants.size() > 0) ? grants[0] : -1), 64'(0));
    chk("rstmid_second", 64'((grants.size() > 1) ? grants[1] : -1), 64'(2));

    // Reset while idle must also rewind the round-robin pointer
    rst = 1'b1; tick(); rst = 1'b0;
    clear_obs(); ch_en_i = 4'hF;
    start_src(2, 1, 1, 4'hF); start_src(3, 1, 1, 4'hF); drive();
    wait_done("rstidle_done", 100);
    chk("rstidle_first", 64'((grants.size() > 0) ? grants[0] : -1), 64'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
